imm_decode_stage: RTL and testbench

Registered immediate-decode stage in the ID path of the RV32I core. It accepts a fetched instruction word and its PC over a valid/ready handshake. It classifies the instruction format, assembles the sign-extended 32-bit immediate (I/S/B/U/J), and presents the result through a 2-entry buffer to the ALU/branch operand mux. It replaces the bare 12-to-32 extension with a pipelined, back-pressurable decode.

---
 rtl/imm_decode_stage.sv | 132 +++++++++++++
 tb/tb_imm_decode_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// RV32I immediate-decode stage: classifies the instruction format, builds the
// sign-extended immediate and queues {imm, type, instr, pc} in a 2-entry buffer.
module imm_decode_stage #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_imm,
    output logic [2:0]      out_type,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [31:0]     imm;
        fmt_e            kind;
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t     mem [2];
    entry_t     head_q;
    entry_t     dec;
    logic       head, tail, head_nxt, tail_nxt;
    logic [1:0] count, count_nxt;
    logic       push, pop;

    always_comb begin
        dec       = '0;
        dec.instr = in_instr;
        dec.pc    = in_pc;
        dec.kind  = FMT_ILL;
        case (in_instr[6:0])
            7'b0010011: begin
                dec.kind = FMT_I;
                // Shift-immediates carry only a 5-bit unsigned shamt
                if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101)
                    dec.imm = {27'b0, in_instr[24:20]};
                else
                    dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec.kind = FMT_I;
                dec.imm  = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec.kind = FMT_S;
                dec.imm  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec.kind = FMT_B;
                dec.imm  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.kind = FMT_U;
                dec.imm  = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.kind = FMT_J;
                dec.imm  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011: dec.kind = FMT_R;
            default:    dec.kind = FMT_ILL;
        endcase
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);

    always_comb begin
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
        head_nxt  = pop ? ~head : head;
        tail_nxt  = push ? ~tail : tail;
        count_nxt = count + {1'b0, push} - {1'b0, pop};
        if (flush) begin
            head_nxt  = 1'b0;
            tail_nxt  = 1'b0;
            count_nxt = 2'd0;
        end
    end

    // head_q mirrors the entry at the next head so outputs come straight from flops;
    // it holds its value when the buffer drains or is flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head_q <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                mem[tail] <= dec;
            if (count_nxt != 2'd0) begin
                if (push && tail == head_nxt)
                    head_q <= dec;
                else
                    head_q <= mem[head_nxt];
            end
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
        end
    end

    assign out_imm   = head_q.imm;
    assign out_type  = head_q.kind;
    assign out_instr = head_q.instr;
    assign out_pc    = head_q.pc;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed decode, backpressure, flush
// and reset steps plus a randomized phase against a queue-based reference model.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_type;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  kind;
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        model_q[$];
    logic [31:0] popped[$];

    imm_decode_stage #(.PC_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_type  (out_type),
        .out_instr (out_instr),
        .out_pc    (out_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Immediate rebuilt with signed shifts of the whole word rather than bit splicing
    function automatic void ref_decode(input logic [31:0] instr, output logic [31:0] imm,
                                       output logic [2:0] kind);
        int s;
        int t;
        s = $signed(instr);
        imm = 32'h0;
        kind = 3'd7;
        case (instr[6:0])
            7'h13: begin
                kind = 3'd1;
                t = s >>> 20;
                imm = (instr[14:12] == 3'd1 || instr[14:12] == 3'd5) ? (instr >> 20) & 32'h1F : t;
            end
            7'h03, 7'h67, 7'h73: begin
                kind = 3'd1;
                t = s >>> 20;
                imm = t;
            end
            7'h23: begin
                kind = 3'd2;
                t = s >>> 25;
                imm = (t << 5) | ((instr >> 7) & 32'h1F);
            end
            7'h63: begin
                kind = 3'd3;
                t = s >>> 31;
                imm = (t << 12) | (((instr >> 7) & 32'h1) << 11)
                    | (((instr >> 25) & 32'h3F) << 5) | (((instr >> 8) & 32'hF) << 1);
            end
            7'h37, 7'h17: begin
                kind = 3'd4;
                imm = instr & 32'hFFFFF000;
            end
            7'h6F: begin
                kind = 3'd5;
                t = s >>> 31;
                imm = (t << 20) | (instr & 32'h000FF000) | (((instr >> 20) & 32'h1) << 11)
                    | (((instr >> 21) & 32'h3FF) << 1);
            end
            7'h33: kind = 3'd0;
            default: kind = 3'd7;
        endcase
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [6:0]  ops [10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) != 0)
            w[6:0] = ops[$urandom_range(0, 9)];
        return w;
    endfunction

    task automatic check_output();
        check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(model_q.size() != 2));
        if (model_q.size() != 0) begin
            check("out_imm", out_imm, model_q[0].imm);
            check("out_type", 32'(out_type), 32'(model_q[0].kind));
            check("out_instr", out_instr, model_q[0].instr);
            check("out_pc", out_pc, model_q[0].pc);
        end
    endtask

    // Called at a falling edge: drives one cycle of inputs, advances the model, checks
    task automatic apply_stimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                  input logic ordy, input logic fl);
        int   size_before;
        exp_t e;
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        if (out_valid && ordy && !fl)
            popped.push_back(out_pc);
        size_before = model_q.size();
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (size_before > 0 && ordy)
                void'(model_q.pop_front());
            if (v && size_before < 2) begin
                ref_decode(instr, e.imm, e.kind);
                e.instr = instr;
                e.pc    = pc;
                model_q.push_back(e);
            end
        end
        @(negedge clk);
        check_output();
    endtask

    initial begin
        logic [31:0] dir_instr [7] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7,
                                       32'h008000EF, 32'h41F0D093, 32'h0000007F};
        logic [31:0] dir_imm   [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                                       32'h00000008, 32'h0000001F, 32'h00000000};
        logic [2:0]  dir_type  [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd7};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_type", 32'(out_type), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed decode");
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b1, dir_instr[i], 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
            check("dir_imm", out_imm, dir_imm[i]);
            check("dir_type", 32'(out_type), 32'(dir_type[i]));
            apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end

        $display("[TB] backpressure");
        popped.delete();
        apply_stimulus(1'b1, 32'h00100093, 32'h0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h00200093, 32'h4, 1'b0, 1'b0);
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        apply_stimulus(1'b1, 32'h00300093, 32'h8, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h00300093, 32'h8, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'h00300093, 32'h8, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("bp_pop_count", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            check("bp_pc0", popped[0], 32'h0);
            check("bp_pc1", popped[1], 32'h4);
            check("bp_pc2", popped[2], 32'h8);
        end

        $display("[TB] streaming");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, gen_instr(), 32'h2000 + 32'(4 * i), 1'b1, 1'b0);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_out_valid", 32'(out_valid), 32'd1);
        end
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("[TB] flush");
        apply_stimulus(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h00200093, 32'h204, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'hFFF00093, 32'h208, 1'b0, 1'b1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        apply_stimulus(1'b1, 32'h00500113, 32'h20C, 1'b1, 1'b0);
        check("post_flush_pc", out_pc, 32'h20C);
        check("post_flush_imm", out_imm, 32'h5);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("[TB] random");
        for (int i = 0; i < 400; i++)
            apply_stimulus(1'($urandom_range(0, 3) != 0), gen_instr(), $urandom,
                           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));

        $display("[TB] reset mid-operation");
        apply_stimulus(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h00200093, 32'h304, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("pre_reset_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 32'hFFF00093, 32'h400, 1'b1, 1'b0);
        check("post_reset_imm", out_imm, 32'hFFFFFFFF);
        check("post_reset_type", 32'(out_type), 32'd1);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
